// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine: fetches a pair of half-panel rows, shifts one BCM bit-plane out,
// latches it and lights the row for BASE_T<<plane cycles, plane by plane, row by row.
module hub75_bcm_scanner #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 4,
    parameter int BPC    = 4,
    parameter int BASE_T = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    output logic                             pix_rd,
    output logic [ADDR_W+$clog2(COLS)-1:0]   pix_addr,
    input  logic [6*BPC-1:0]                 pix_data,
    output logic                             r1,
    output logic                             g1,
    output logic                             b1,
    output logic                             r2,
    output logic                             g2,
    output logic                             b2,
    output logic                             clk,
    output logic                             latch,
    output logic                             oe,
    output logic [ADDR_W-1:0]                row_addr,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int CW  = $clog2(COLS);
    localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DW  = $clog2(BASE_T + 1) + BPC;
    localparam int PAW = ADDR_W + CW;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_BLANK    = 3'd3;
    localparam logic [2:0] S_LATCH    = 3'd4;
    localparam logic [2:0] S_DISPLAY  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [PW-1:0]     plane_q, plane_d;
    logic [CW-1:0]     col_q, col_d;
    logic              phase_q, phase_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic              wrap;

    logic              pix_rd_q, pix_rd_d;
    logic [PAW-1:0]    pix_addr_q, pix_addr_d;
    logic [5:0]        colour_q, colour_d;
    logic [5:0]        plane_bits;
    logic              clk_q, clk_d;
    logic              latch_q, latch_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    // Channel gi of pix_data is {b1,g1,r1,b2,g2,r2}[gi] counted from the LSB end.
    for (genvar gi = 0; gi < 6; gi++) begin : g_chan
        logic [BPC-1:0] chan_word;
        assign chan_word      = pix_data[gi*BPC +: BPC];
        assign plane_bits[gi] = chan_word[plane_q];
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        plane_d = plane_q;
        col_d   = col_q;
        phase_d = phase_q;
        dcnt_d  = dcnt_q;
        wrap    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_PREFETCH;
                    phase_d = 1'b0;
                end
            end
            S_PREFETCH: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                    phase_d = 1'b0;
                    col_d   = '0;
                end
            end
            S_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (col_q == CW'(COLS - 1)) begin
                    state_d = S_BLANK;
                    phase_d = 1'b0;
                end else begin
                    col_d   = col_q + CW'(1);
                    phase_d = 1'b0;
                end
            end
            S_BLANK: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                dcnt_d  = (DW'(BASE_T) << plane_q) - DW'(1);
            end
            S_DISPLAY: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - DW'(1);
                end else begin
                    if (plane_q == PW'(BPC - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + ADDR_W'(1);
                        wrap    = (row_q == {ADDR_W{1'b1}});
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                    // enable is only honoured here, at the plane boundary
                    if (enable) begin
                        state_d = S_PREFETCH;
                        phase_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        plane_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
                plane_d = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Pin outputs are registered: each is decoded from the state about to be entered.
    always_comb begin
        pix_rd_d = ((state_d == S_PREFETCH) && !phase_d) ||
                   ((state_d == S_SHIFT) && !phase_d && (col_d != CW'(COLS - 1)));

        pix_addr_d = pix_addr_q;
        if (state_d == S_PREFETCH && !phase_d) begin
            pix_addr_d = {row_d, {CW{1'b0}}};
        end else if (pix_rd_d) begin
            pix_addr_d = {row_d, col_d + CW'(1)};
        end

        colour_d = '0;
        if (state_d == S_SHIFT) begin
            colour_d = phase_d ? colour_q : plane_bits;
        end

        clk_d        = (state_d == S_SHIFT) && phase_d;
        latch_d      = (state_d == S_LATCH);
        oe_d         = (state_d != S_DISPLAY);
        row_addr_d   = (state_d == S_BLANK) ? row_q : row_addr_q;
        busy_d       = (state_d != S_IDLE);
        frame_done_d = wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            dcnt_q       <= '0;
            pix_rd_q     <= 1'b0;
            pix_addr_q   <= '0;
            colour_q     <= '0;
            clk_q        <= 1'b0;
            latch_q      <= 1'b0;
            oe_q         <= 1'b1;
            row_addr_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            dcnt_q       <= dcnt_d;
            pix_rd_q     <= pix_rd_d;
            pix_addr_q   <= pix_addr_d;
            colour_q     <= colour_d;
            clk_q        <= clk_d;
            latch_q      <= latch_d;
            oe_q         <= oe_d;
            row_addr_q   <= row_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_rd                   = pix_rd_q;
    assign pix_addr                 = pix_addr_q;
    assign {r2, g2, b2, r1, g1, b1} = colour_q;
    assign clk                      = clk_q;
    assign latch                    = latch_q;
    assign oe                       = oe_q;
    assign row_addr                 = row_addr_q;
    assign busy                     = busy_q;
    assign frame_done               = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Bench for hub75_bcm_scanner: a plane-position model predicts every output each cycle,
// plus directed checks of plane lengths, bit-plane mapping, row wrap, enable drop and reset.
module tb_hub75_bcm_scanner;

    localparam int C    = 4;
    localparam int AW   = 2;
    localparam int B    = 2;
    localparam int BT   = 2;
    localparam int CW   = 2;
    localparam int PAW  = AW + CW;
    localparam int ROWS = 1 << AW;
    localparam int OW   = 1 + PAW + 6 + 3 + AW + 2;

    logic            clock = 0;
    logic            reset = 1;
    logic            enable = 0;
    logic            pix_rd;
    logic [PAW-1:0]  pix_addr;
    logic [6*B-1:0]  pix_data = '0;
    logic            r1, g1, b1, r2, g2, b2;
    logic            clk, latch, oe;
    logic [AW-1:0]   row_addr;
    logic            busy, frame_done;

    hub75_bcm_scanner #(.COLS(C), .ADDR_W(AW), .BPC(B), .BASE_T(BT)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .clk(clk), .latch(latch), .oe(oe), .row_addr(row_addr),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // frame-buffer RAM with one-cycle registered read
    logic [6*B-1:0] mem [C*ROWS];
    always @(posedge clock) if (pix_rd) pix_data <= mem[pix_addr];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else if (checks - passed <= 40)
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    endtask

    logic [OW-1:0] dut_vec;
    assign dut_vec = {pix_rd, pix_addr, r1, g1, b1, r2, g2, b2, clk, latch, oe, row_addr, busy, frame_done};

    // ---------------- behavioural model: position k inside the current plane ----------------
    bit             model_on = 0;
    bit             m_active = 0;
    int             m_k = 0, m_row = 0, m_plane = 0;
    logic [PAW-1:0] exp_addr = '0;
    logic [AW-1:0]  exp_ra = '0;
    logic           exp_fd = 0;

    function automatic int plane_len(int p);
        return 2 + 2*C + 2 + (BT << p);
    endfunction

    function automatic bit is_read(int k);
        return (k == 0) || (k >= 2 && k < 2 + 2*C && ((k - 2) % 2 == 0) && ((k - 2) / 2 < C - 1));
    endfunction

    function automatic logic [5:0] colour_of(logic [6*B-1:0] w, int p);
        return {w[2*B+p], w[B+p], w[p], w[5*B+p], w[4*B+p], w[3*B+p]};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        int k;
        bit shift, ph, rd;
        int col;
        logic [5:0] colour;
        if (!m_active)
            return {1'b0, exp_addr, 6'b0, 1'b0, 1'b0, 1'b1, exp_ra, 1'b0, exp_fd};
        k      = m_k;
        shift  = (k >= 2 && k < 2 + 2*C);
        col    = (k - 2) / 2;
        ph     = ((k - 2) % 2) == 1;
        rd     = is_read(k);
        colour = shift ? colour_of(mem[m_row*C + col], m_plane) : 6'b0;
        return {rd, exp_addr, colour, shift && ph, k == 3 + 2*C, !(k >= 4 + 2*C), exp_ra, 1'b1, exp_fd};
    endfunction

    initial forever begin
        @(posedge clock);
        if (reset) begin
            model_on = 1; m_active = 0; m_k = 0; m_row = 0; m_plane = 0;
            exp_addr = '0; exp_ra = '0; exp_fd = 0;
        end else if (model_on) begin
            exp_fd = 0;
            if (!m_active) begin
                if (enable) begin m_active = 1; m_k = 0; end
            end else if (m_k == plane_len(m_plane) - 1) begin
                if (m_plane == B - 1) begin
                    m_plane = 0;
                    exp_fd  = (m_row == ROWS - 1);
                    m_row   = (m_row + 1) % ROWS;
                end else begin
                    m_plane++;
                end
                if (enable) m_k = 0;
                else begin m_active = 0; m_row = 0; m_plane = 0; end
            end else begin
                m_k++;
            end
            if (m_active && m_k == 2 + 2*C) exp_ra = AW'(m_row);
            if (m_active && is_read(m_k))
                exp_addr = PAW'(m_row*C + ((m_k == 0) ? 0 : (m_k - 2) / 2 + 1));
        end
    end

    initial forever begin
        @(negedge clock);
        if (model_on) check("cycle_outputs", dut_vec, exp_vec());
    end

    // ---------------- monitors ----------------
    bit            rec_on = 0;
    int            ra_q[$];
    logic [AW-1:0] prev_ra = '0;
    int            fd_cnt = 0;

    initial forever begin
        @(negedge clock);
        if (row_addr !== prev_ra) begin
            check("row_addr_change_blanked", oe, 1);
            if (rec_on) ra_q.push_back(int'(row_addr));
            prev_ra = row_addr;
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    // entered at the negedge of plane cycle 0; returns at cycle 0 of the next plane or first IDLE cycle
    task automatic run_plane(output int len, output int oe_lo, output int rises,
                             output logic [15:0] seq, output int lat_at, output int lat_n);
        int  i;
        bit  done;
        logic prev_clk;
        i = 0; oe_lo = 0; rises = 0; seq = '0; lat_at = -1; lat_n = 0; prev_clk = 0; done = 0;
        while (!done && i < 1000) begin
            if (i > 0 && (busy == 1'b0 || (pix_rd && pix_addr[CW-1:0] == '0))) begin
                done = 1;
            end else begin
                if (!oe) oe_lo++;
                if (clk && !prev_clk) begin
                    if (rises < 16) seq[rises] = r1;
                    rises++;
                end
                prev_clk = clk;
                if (latch) begin
                    if (lat_at < 0) lat_at = i;
                    lat_n++;
                end
                @(negedge clock);
                i++;
            end
        end
        len = i;
        if (!done) begin
            checks++;
            $display("FAIL plane_bound got %0d cycles exp plane end", i);
        end
    endtask

    int len, oe_lo, rises, lat_at, lat_n, n, pulses;
    logic [15:0] seq;
    logic [63:0] packed_ra;

    initial begin
        // RAM holds the column index in every channel
        for (int a = 0; a < C*ROWS; a++)
            for (int ch = 0; ch < 6; ch++) mem[a][ch*B +: B] = B'(a % C);

        reset = 1; enable = 1;
        repeat (3) @(negedge clock);
        check("reset_values", dut_vec, {1'b0, 4'h0, 6'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0});
        reset = 0;
        @(negedge clock);
        check("first_read_after_release", {busy, pix_rd, pix_addr}, {1'b1, 1'b1, 4'h0});

        run_plane(len, oe_lo, rises, seq, lat_at, lat_n);
        check("p0_len", len, 14);
        check("p0_oe_low", oe_lo, 2);
        check("p0_clk_rises", rises, 4);
        check("p0_r1_seq", seq, 16'b1010);
        check("p0_latch_pos", lat_at, 11);
        check("p0_latch_cycles", lat_n, 1);

        run_plane(len, oe_lo, rises, seq, lat_at, lat_n);
        check("p1_len", len, 16);
        check("p1_oe_low", oe_lo, 4);
        check("p1_clk_rises", rises, 4);
        check("p1_r1_seq", seq, 16'b1100);
        check("p1_latch_cycles", lat_n, 1);

        // row 1 plane 0: drop enable in SHIFT
        repeat (5) @(negedge clock);
        enable = 0;
        n = 5;
        while (busy && n < 300) begin @(negedge clock); n++; end
        check("drop_plane_len", n, 14);
        check("drop_idle_oe", oe, 1);
        repeat (4) @(negedge clock);
        check("drop_stays_idle", busy, 0);

        enable = 1; rec_on = 1; ra_q.delete(); fd_cnt = 0;
        @(negedge clock);
        check("restart_row0", {pix_rd, pix_addr}, {1'b1, 4'h0});
        for (int pl = 0; pl < 9; pl++) begin
            run_plane(len, oe_lo, rises, seq, lat_at, lat_n);
            check("frame_plane_len", len, (pl % 2 == 1) ? 16 : 14);
        end
        rec_on = 0;
        packed_ra = '0;
        foreach (ra_q[i]) packed_ra = (packed_ra << 4) | 64'(ra_q[i]);
        check("row_addr_count", ra_q.size(), 5);
        check("row_addr_seq", packed_ra, 64'h01230);
        check("frame_done_pulses", fd_cnt, 1);

        // reset during DISPLAY
        n = 0;
        while (oe && n < 300) begin @(negedge clock); n++; end
        check("reached_display", oe, 0);
        reset = 1;
        @(negedge clock);
        reset = 0; enable = 0;
        check("mid_display_reset", {oe, busy, clk, latch}, 4'b1000);
        pulses = 0;
        repeat (6) begin
            @(negedge clock);
            if (clk || latch) pulses++;
        end
        check("no_pulse_after_reset", pulses, 0);

        // randomized frames with random enable and occasional resets
        for (int round = 0; round < 4; round++) begin
            reset = 1;
            @(negedge clock);
            for (int a = 0; a < C*ROWS; a++) mem[a] = (6*B)'($urandom);
            @(negedge clock);
            reset = 0; enable = 1;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(negedge clock);
                enable = ($urandom_range(0, 99) < 85);
                reset  = ($urandom_range(0, 599) == 0);
            end
        end
        reset = 0; enable = 0;
        repeat (4) @(negedge clock);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
